// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw switches in, debounced levels, edge strobes and any-key flag out.
interface sw_debounce_if #(
    parameter int N_SW = 8
);
    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_clean;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
    logic            any_on;

    modport master (
        output sw_raw,
        input  sw_clean, sw_rise, sw_fall, any_on
    );

    modport slave (
        input  sw_raw,
        output sw_clean, sw_rise, sw_fall, any_on
    );
endinterface

// File: rtl/sw_debounce.sv
// Per-key debouncer: two-flop synchronizer, saturating stability counter, press/release strobes.
module sw_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // A bounce back to the accepted level restarts the count, so only an
    // uninterrupted run of DEBOUNCE_CYCLES mismatches is accepted.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            clean_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = !sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

module sw_debounce #(
    parameter int N_SW            = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic         clk,
    input  logic         reset,
    sw_debounce_if.slave bus
);
    logic [N_SW-1:0] clean_w, rise_w, fall_w;

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (bus.sw_raw[i]),
            .clean_o(clean_w[i]),
            .rise_o (rise_w[i]),
            .fall_o (fall_w[i])
        );
    end

    assign bus.sw_clean = clean_w;
    assign bus.sw_rise  = rise_w;
    assign bus.sw_fall  = fall_w;
    assign bus.any_on   = |clean_w;
endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4: vector table plus corner-case sequences.
module tb_sw_debounce;
    logic clk = 1'b0;
    logic reset;
    int   n_run  = 0;
    int   n_fail = 0;

    sw_debounce_if #(.N_SW(8)) bus ();

    sw_debounce #(.N_SW(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] raw;
        logic [7:0] clean;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       any;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic [7:0] raw, input logic [7:0] clean,
                       input logic [7:0] rise, input logic [7:0] fall, input logic any);
        vec_t v;
        v.rst = rst; v.raw = raw; v.clean = clean; v.rise = rise; v.fall = fall; v.any = any;
        vq.push_back(v);
    endtask

    task automatic add_n(input int n, input logic [7:0] raw, input logic [7:0] clean);
        for (int k = 0; k < n; k++) add(1'b0, raw, clean, 8'h00, 8'h00, |clean);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same offset.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] clean, input logic [7:0] rise,
                       input logic [7:0] fall, input logic any);
        n_run++;
        if (bus.sw_clean !== clean || bus.sw_rise !== rise || bus.sw_fall !== fall || bus.any_on !== any) begin
            n_fail++;
            $display("FAIL %s: got clean=%h rise=%h fall=%h any=%b, want clean=%h rise=%h fall=%h any=%b",
                     name, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.any_on, clean, rise, fall, any);
        end
    endtask

    task automatic settle(input logic [7:0] raw);
        bus.sw_raw = raw;
        repeat (10) step();
    endtask

    int rises;

    initial begin
        reset      = 1'b1;
        bus.sw_raw = 8'hFF;

        // Reset held with all switches up, then full-latency acceptance.
        add(1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        add_n(5, 8'hFF, 8'h00);
        add(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1);
        add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1);
        add_n(5, 8'h00, 8'hFF);
        add(1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0);
        add(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        // Clean press and release on key 2.
        add_n(5, 8'h04, 8'h00);
        add(1'b0, 8'h04, 8'h04, 8'h04, 8'h00, 1'b1);
        add(1'b0, 8'h04, 8'h04, 8'h00, 8'h00, 1'b1);
        add_n(5, 8'h00, 8'h04);
        add(1'b0, 8'h00, 8'h00, 8'h00, 8'h04, 1'b0);
        add(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        foreach (vq[i]) begin
            reset      = vq[i].rst;
            bus.sw_raw = vq[i].raw;
            step();
            chk($sformatf("vec%0d", i), vq[i].clean, vq[i].rise, vq[i].fall, vq[i].any);
        end
        reset = 1'b0;

        // Bounce on key 0: 3-cycle excursions never reach the output.
        for (int b = 0; b < 4; b++) begin
            bus.sw_raw = (b % 2 == 0) ? 8'h01 : 8'h00;
            for (int k = 0; k < 3; k++) begin
                step();
                chk("bounce", 8'h00, 8'h00, 8'h00, 1'b0);
            end
        end
        bus.sw_raw = 8'h00;
        repeat (4) begin
            step();
            chk("bounce_tail", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        bus.sw_raw = 8'h01;
        rises = 0;
        repeat (8) begin
            step();
            if (bus.sw_rise[0]) rises++;
        end
        n_run++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL bounce_single_rise: got %0d rises, want 1", rises);
        end
        chk("bounce_held", 8'h01, 8'h00, 8'h00, 1'b1);
        settle(8'h00);

        // Keys 0 and 7 pressed together strobe on the same cycle.
        bus.sw_raw = 8'h81;
        repeat (5) begin
            step();
            chk("simul_wait", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        step();
        chk("simul_rise", 8'h81, 8'h81, 8'h00, 1'b1);
        step();
        chk("simul_after", 8'h81, 8'h00, 8'h00, 1'b1);
        settle(8'h00);
        chk("simul_released", 8'h00, 8'h00, 8'h00, 1'b0);

        // Reset arriving mid-count discards it; re-acceptance takes full latency.
        bus.sw_raw = 8'h20;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("rst_mid", 8'h00, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        repeat (5) begin
            step();
            chk("rst_reaccept_wait", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        step();
        chk("rst_reaccept", 8'h20, 8'h20, 8'h00, 1'b1);
        settle(8'h00);

        // A one-cycle dip restarts key 7's count from the final rising edge.
        bus.sw_raw = 8'h80;
        repeat (3) step();
        bus.sw_raw = 8'h00;
        step();
        bus.sw_raw = 8'h80;
        repeat (5) begin
            step();
            chk("restart_wait", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        step();
        chk("restart_rise", 8'h80, 8'h80, 8'h00, 1'b1);
        step();
        chk("restart_after", 8'h80, 8'h00, 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
